// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : config_pkg
//  Description : Global core configuration record shared by backend blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package config_pkg;

    typedef struct packed {
        int unsigned ILEN;
        int unsigned PLEN;
        int unsigned INSTR_PER_FETCH;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{ILEN: 32, PLEN: 32, INSTR_PER_FETCH: 4};

endpackage : config_pkg
`default_nettype wire

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Micro-op format, functional-unit and sub-op encodings, and
//                RV32 opcode constants used by the decode stage.
//  Revision    : 1.0  initial release
// ============================================================================
package decode_pkg;

    typedef enum logic [2:0] {
        FU_NONE = 3'd0,
        FU_ALU  = 3'd1,
        FU_BRU  = 3'd2,
        FU_LSU  = 3'd3,
        FU_MUL  = 3'd4,
        FU_DIV  = 3'd5,
        FU_CSR  = 3'd6
    } fu_e;

    // ALU sub-ops
    localparam logic [4:0] c_op_add    = 5'd0;
    localparam logic [4:0] c_op_sub    = 5'd1;
    localparam logic [4:0] c_op_sll    = 5'd2;
    localparam logic [4:0] c_op_slt    = 5'd3;
    localparam logic [4:0] c_op_sltu   = 5'd4;
    localparam logic [4:0] c_op_xor    = 5'd5;
    localparam logic [4:0] c_op_srl    = 5'd6;
    localparam logic [4:0] c_op_sra    = 5'd7;
    localparam logic [4:0] c_op_or     = 5'd8;
    localparam logic [4:0] c_op_and    = 5'd9;
    localparam logic [4:0] c_op_lui    = 5'd10;
    localparam logic [4:0] c_op_auipc  = 5'd11;
    localparam logic [4:0] c_op_nop    = 5'd12;
    // BRU sub-ops: conditional branches use {2'b00, funct3}
    localparam logic [4:0] c_op_jal    = 5'd8;
    localparam logic [4:0] c_op_jalr   = 5'd9;
    // LSU sub-ops: loads {2'b00, funct3}, stores {2'b01, funct3}
    // MUL/DIV sub-ops: {2'b00, funct3}
    // CSR sub-ops: CSR accesses {2'b00, funct3}, plus environment calls
    localparam logic [4:0] c_op_ecall  = 5'd8;
    localparam logic [4:0] c_op_ebreak = 5'd9;

    // RV32 major opcodes
    localparam logic [6:0] c_opc_lui      = 7'b0110111;
    localparam logic [6:0] c_opc_auipc    = 7'b0010111;
    localparam logic [6:0] c_opc_jal      = 7'b1101111;
    localparam logic [6:0] c_opc_jalr     = 7'b1100111;
    localparam logic [6:0] c_opc_branch   = 7'b1100011;
    localparam logic [6:0] c_opc_load     = 7'b0000011;
    localparam logic [6:0] c_opc_store    = 7'b0100011;
    localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
    localparam logic [6:0] c_opc_op       = 7'b0110011;
    localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
    localparam logic [6:0] c_opc_system   = 7'b1110011;

    localparam logic [31:0] c_instr_ecall  = 32'h0000_0073;
    localparam logic [31:0] c_instr_ebreak = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        fu_e         fu;
        logic [4:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_en;
        logic        rs2_en;
        logic        rd_we;
        logic [31:0] imm;
        logic        illegal;
        logic        is_branch;
        logic        is_jump;
    } uop_t;

    // Map funct3 (plus the funct7[5] alternate bit) onto an ALU sub-op
    function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'd0:    op = alt ? c_op_sub : c_op_add;
            3'd1:    op = c_op_sll;
            3'd2:    op = c_op_slt;
            3'd3:    op = c_op_sltu;
            3'd4:    op = c_op_xor;
            3'd5:    op = alt ? c_op_sra : c_op_srl;
            3'd6:    op = c_op_or;
            default: op = c_op_and;
        endcase
        return op;
    endfunction

endpackage : decode_pkg
`default_nettype wire

// File: rtl/rv_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : rv_decoder
//  Description : Combinational RV32IM single-instruction decoder producing
//                one micro-op. Illegal encodings still emit a uop so the
//                exception can be raised in program order.
//  Revision    : 1.0  initial release
// ============================================================================
module rv_decoder
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output uop_t        uop
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    logic        w_legal;
    fu_e         w_fu;
    logic [4:0]  w_op;
    logic        w_rs1_en;
    logic        w_rs2_en;
    logic        w_writes;
    logic [31:0] w_imm;
    logic        w_branch;
    logic        w_jump;

    assign w_opc   = instr[6:0];
    assign w_f3    = instr[14:12];
    assign w_f7    = instr[31:25];
    assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_u = {instr[31:12], 12'd0};
    assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Classify the opcode and validate funct3/funct7; shift-immediates keep the raw I-immediate
    always_comb begin
        w_legal  = 1'b0;
        w_fu     = FU_NONE;
        w_op     = 5'd0;
        w_rs1_en = 1'b0;
        w_rs2_en = 1'b0;
        w_writes = 1'b0;
        w_imm    = 32'd0;
        w_branch = 1'b0;
        w_jump   = 1'b0;
        case (w_opc)
            c_opc_lui: begin
                w_legal  = 1'b1;
                w_fu     = FU_ALU;
                w_op     = c_op_lui;
                w_writes = 1'b1;
                w_imm    = w_imm_u;
            end
            c_opc_auipc: begin
                w_legal  = 1'b1;
                w_fu     = FU_ALU;
                w_op     = c_op_auipc;
                w_writes = 1'b1;
                w_imm    = w_imm_u;
            end
            c_opc_jal: begin
                w_legal  = 1'b1;
                w_fu     = FU_BRU;
                w_op     = c_op_jal;
                w_writes = 1'b1;
                w_imm    = w_imm_j;
                w_jump   = 1'b1;
            end
            c_opc_jalr: begin
                w_legal  = (w_f3 == 3'd0);
                w_fu     = FU_BRU;
                w_op     = c_op_jalr;
                w_rs1_en = 1'b1;
                w_writes = 1'b1;
                w_imm    = w_imm_i;
                w_jump   = 1'b1;
            end
            c_opc_branch: begin
                w_legal  = (w_f3 != 3'd2) && (w_f3 != 3'd3);
                w_fu     = FU_BRU;
                w_op     = {2'b00, w_f3};
                w_rs1_en = 1'b1;
                w_rs2_en = 1'b1;
                w_imm    = w_imm_b;
                w_branch = 1'b1;
            end
            c_opc_load: begin
                w_legal  = (w_f3 != 3'd3) && (w_f3 != 3'd6) && (w_f3 != 3'd7);
                w_fu     = FU_LSU;
                w_op     = {2'b00, w_f3};
                w_rs1_en = 1'b1;
                w_writes = 1'b1;
                w_imm    = w_imm_i;
            end
            c_opc_store: begin
                w_legal  = (w_f3 < 3'd3);
                w_fu     = FU_LSU;
                w_op     = {2'b01, w_f3};
                w_rs1_en = 1'b1;
                w_rs2_en = 1'b1;
                w_imm    = w_imm_s;
            end
            c_opc_op_imm: begin
                w_fu     = FU_ALU;
                w_op     = alu_op(w_f3, (w_f3 == 3'd5) && w_f7[5]);
                w_rs1_en = 1'b1;
                w_writes = 1'b1;
                w_imm    = w_imm_i;
                case (w_f3)
                    3'd1:    w_legal = (w_f7 == 7'b0000000);
                    3'd5:    w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                    default: w_legal = 1'b1;
                endcase
            end
            c_opc_op: begin
                w_rs1_en = 1'b1;
                w_rs2_en = 1'b1;
                w_writes = 1'b1;
                case (w_f7)
                    7'b0000000: begin
                        w_legal = 1'b1;
                        w_fu    = FU_ALU;
                        w_op    = alu_op(w_f3, 1'b0);
                    end
                    7'b0100000: begin
                        w_legal = (w_f3 == 3'd0) || (w_f3 == 3'd5);
                        w_fu    = FU_ALU;
                        w_op    = alu_op(w_f3, 1'b1);
                    end
                    7'b0000001: begin
                        w_legal = 1'b1;
                        w_fu    = w_f3[2] ? FU_DIV : FU_MUL;
                        w_op    = {2'b00, w_f3};
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            c_opc_misc_mem: begin
                // FENCE is a no-op for an in-order memory pipe
                w_legal = (w_f3 == 3'd0);
                w_fu    = FU_ALU;
                w_op    = c_op_nop;
            end
            c_opc_system: begin
                w_fu = FU_CSR;
                if (w_f3 == 3'd0) begin
                    w_legal = (instr == c_instr_ecall) || (instr == c_instr_ebreak);
                    w_op    = instr[20] ? c_op_ebreak : c_op_ecall;
                end else begin
                    // CSR address travels in imm; immediate forms reuse the rs1 field as zimm
                    w_legal  = (w_f3 != 3'd4);
                    w_op     = {2'b00, w_f3};
                    w_rs1_en = ~w_f3[2];
                    w_writes = 1'b1;
                    w_imm    = {20'd0, instr[31:20]};
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Assemble the uop; illegal lanes carry only pc/instr/raw register fields
    always_comb begin
        uop         = '0;
        uop.pc      = pc;
        uop.instr   = instr;
        uop.rs1     = instr[19:15];
        uop.rs2     = instr[24:20];
        uop.rd      = instr[11:7];
        uop.illegal = ~w_legal;
        if (w_legal) begin
            uop.fu        = w_fu;
            uop.op        = w_op;
            uop.rs1_en    = w_rs1_en;
            uop.rs2_en    = w_rs2_en;
            uop.rd_we     = w_writes && (instr[11:7] != 5'd0);
            uop.imm       = w_imm;
            uop.is_branch = w_branch;
            uop.is_jump   = w_jump;
        end
    end

endmodule : rv_decoder
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Decodes a group of DECODE_WIDTH instructions from the
//                ibuffer and holds it in a one-deep valid/ready pipeline
//                register towards rename. Flush discards the held group.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter config_pkg::cfg_t Cfg          = config_pkg::EmptyCfg,
    parameter int unsigned      DECODE_WIDTH = Cfg.INSTR_PER_FETCH,
    parameter int unsigned      ILEN         = Cfg.ILEN,
    parameter int unsigned      PLEN         = Cfg.PLEN
)(
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic                                 ibuf_valid_i,
    output logic                                 ibuf_ready_o,
    input  logic [DECODE_WIDTH*ILEN-1:0]         ibuf_instrs_i,
    input  logic [DECODE_WIDTH*PLEN-1:0]         ibuf_pcs_i,
    output logic                                 dec_valid_o,
    input  logic                                 dec_ready_i,
    output logic [DECODE_WIDTH*$bits(uop_t)-1:0] dec_uops_o
);

    logic                          r_valid;
    uop_t [DECODE_WIDTH-1:0]       r_uops;
    uop_t [DECODE_WIDTH-1:0]       w_dec_uops;
    logic                          w_fire_in;
    logic                          w_fire_out;

    generate
        for (genvar l = 0; l < DECODE_WIDTH; l++) begin : g_lane
            rv_decoder u_rv_decoder (
                .instr (ibuf_instrs_i[l*ILEN +: ILEN]),
                .pc    (ibuf_pcs_i[l*PLEN +: PLEN]),
                .uop   (w_dec_uops[l])
            );
        end
    endgenerate

    // Reset gates ready too so the ibuffer never pops a group that would be dropped
    assign ibuf_ready_o = !rst_i && !flush_i && (!r_valid || dec_ready_i);
    assign w_fire_in    = ibuf_valid_i && ibuf_ready_o;
    assign w_fire_out   = r_valid && dec_ready_i;
    assign dec_valid_o  = r_valid;
    assign dec_uops_o   = r_uops;

    // Pipeline register: reset, then flush, then load, then drain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_uops  <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_fire_in) begin
            r_valid <= 1'b1;
            r_uops  <= w_dec_uops;
        end else if (w_fire_out) begin
            r_valid <= 1'b0;
        end
    end

endmodule : decode_stage
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage: directed decode table,
//                reset/backpressure/flush sequences and random traffic
//                against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_stage;
    import decode_pkg::*;

    localparam int W  = 4;
    localparam int UW = $bits(uop_t);

    typedef struct {
        logic [31:0] instr;
        fu_e         fu;
        logic        rd_we;
        logic        rs1_en;
        logic        rs2_en;
        logic        illegal;
        logic        is_branch;
        logic        is_jump;
        logic [31:0] imm;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              ibuf_valid;
    logic              ibuf_ready;
    logic [W*32-1:0]   instrs;
    logic [W*32-1:0]   pcs;
    logic              dec_valid;
    logic              dec_ready;
    logic [W*UW-1:0]   uops;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t            vecs [16];
    logic [4:0]      alu_tab [8];
    logic [W*32-1:0] ga, gb, gc, pa, pb, pc_c;
    logic [W*32-1:0] ri, rp;
    logic [W*UW-1:0] mgrp;
    logic            mvalid, rv, rdr, rfl, exp_rdy;
    uop_t            u;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .ibuf_valid_i  (ibuf_valid),
        .ibuf_ready_o  (ibuf_ready),
        .ibuf_instrs_i (instrs),
        .ibuf_pcs_i    (pcs),
        .dec_valid_o   (dec_valid),
        .dec_ready_i   (dec_ready),
        .dec_uops_o    (uops)
    );

    task automatic check(input string name, input logic [W*UW-1:0] act, input logic [W*UW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive all inputs just after the falling edge, then let combinational outputs settle
    task automatic drive(input logic r, input logic f, input logic v,
                         input logic [W*32-1:0] ins, input logic [W*32-1:0] p, input logic dr);
        @(negedge clk);
        rst        = r;
        flush      = f;
        ibuf_valid = v;
        instrs     = ins;
        pcs        = p;
        dec_ready  = dr;
        #1;
    endtask

    function automatic vec_t mkv(input logic [31:0] i, input fu_e f, input logic we, input logic e1,
                                 input logic e2, input logic il, input logic br, input logic jp,
                                 input logic [31:0] im);
        vec_t v;
        v.instr = i; v.fu = f; v.rd_we = we; v.rs1_en = e1; v.rs2_en = e2;
        v.illegal = il; v.is_branch = br; v.is_jump = jp; v.imm = im;
        return v;
    endfunction

    // Reference decode built from the ISA rules: immediates via arithmetic shifts and masks,
    // funct3 legality via bitmask lookups
    function automatic uop_t ref_decode(input logic [31:0] ins, input logic [31:0] p);
        uop_t        r;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] ii, is_, ib, iu, ij, imm;
        logic        ok, wr, e1, e2, br, jp;
        fu_e         fu;
        logic [4:0]  op;
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        ii  = 32'($signed(ins) >>> 20);
        is_ = (ii & ~32'h1F) | 32'(ins[11:7]);
        ib  = (is_ & ~32'h801) | (32'(ins[7]) << 11);
        iu  = ins & 32'hFFFF_F000;
        ij  = (ii & 32'hFFF0_07FE) | (ins & 32'h000F_F000) | (32'(ins[20]) << 11);
        ok = 1'b0; wr = 1'b0; e1 = 1'b0; e2 = 1'b0; br = 1'b0; jp = 1'b0;
        fu = FU_NONE; op = 5'd0; imm = 32'd0;
        case (opc)
            7'b0110111: begin ok = 1; fu = FU_ALU; op = c_op_lui; wr = 1; imm = iu; end
            7'b0010111: begin ok = 1; fu = FU_ALU; op = c_op_auipc; wr = 1; imm = iu; end
            7'b1101111: begin ok = 1; fu = FU_BRU; op = c_op_jal; wr = 1; imm = ij; jp = 1; end
            7'b1100111: begin ok = (f3 == 0); fu = FU_BRU; op = c_op_jalr; e1 = 1; wr = 1; imm = ii; jp = 1; end
            7'b1100011: begin ok = ((8'hF3 >> f3) & 8'h1) != 0; fu = FU_BRU; op = 5'(f3); e1 = 1; e2 = 1; imm = ib; br = 1; end
            7'b0000011: begin ok = ((8'h37 >> f3) & 8'h1) != 0; fu = FU_LSU; op = 5'(f3); e1 = 1; wr = 1; imm = ii; end
            7'b0100011: begin ok = ((8'h07 >> f3) & 8'h1) != 0; fu = FU_LSU; op = 5'(f3) + 5'd8; e1 = 1; e2 = 1; imm = is_; end
            7'b0010011: begin
                fu = FU_ALU; e1 = 1; wr = 1; imm = ii;
                op = alu_tab[f3];
                if (f3 == 1) ok = (f7 == 0);
                else if (f3 == 5) begin
                    ok = (f7 == 0) || (f7 == 7'h20);
                    if (f7 == 7'h20) op = c_op_sra;
                end else ok = 1;
            end
            7'b0110011: begin
                e1 = 1; e2 = 1; wr = 1;
                if (f7 == 0) begin ok = 1; fu = FU_ALU; op = alu_tab[f3]; end
                else if (f7 == 7'h20) begin
                    ok = (f3 == 0) || (f3 == 5); fu = FU_ALU;
                    op = (f3 == 0) ? c_op_sub : c_op_sra;
                end else if (f7 == 7'h01) begin
                    ok = 1; fu = (f3 >= 4) ? FU_DIV : FU_MUL; op = 5'(f3);
                end
            end
            7'b0001111: begin ok = (f3 == 0); fu = FU_ALU; op = c_op_nop; end
            7'b1110011: begin
                fu = FU_CSR;
                if (ins == 32'h0000_0073) begin ok = 1; op = c_op_ecall; end
                else if (ins == 32'h0010_0073) begin ok = 1; op = c_op_ebreak; end
                else if (f3 != 0 && f3 != 4) begin
                    ok = 1; op = 5'(f3); e1 = (f3 < 4); wr = 1; imm = ins >> 20;
                end
            end
            default: ok = 1'b0;
        endcase
        r = '0;
        r.pc = p; r.instr = ins;
        r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; r.rd = ins[11:7];
        r.illegal = !ok;
        if (ok) begin
            r.fu = fu; r.op = op; r.rs1_en = e1; r.rs2_en = e2;
            r.rd_we = wr && (ins[11:7] != 0);
            r.imm = imm; r.is_branch = br; r.is_jump = jp;
        end
        return r;
    endfunction

    function automatic logic [W*UW-1:0] ref_group(input logic [W*32-1:0] ins, input logic [W*32-1:0] p);
        logic [W*UW-1:0] g;
        for (int l = 0; l < W; l++) g[l*UW +: UW] = ref_decode(ins[l*32 +: 32], p[l*32 +: 32]);
        return g;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [11];
        logic [31:0] w;
        int          k;
        opcs = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};
        w = $urandom;
        k = $urandom_range(0, 13);
        if (k < 11) begin
            w[6:0] = opcs[k];
            if (k == 8 || k == 7) begin
                case ($urandom_range(0, 3))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    2: w[31:25] = 7'h01;
                    default: ;
                endcase
            end
        end else if (k == 11) begin
            w = ($urandom_range(0, 1) == 0) ? 32'h0000_0073 : 32'h0010_0073;
        end
        return w;
    endfunction

    function automatic logic [W*32-1:0] rand_group();
        logic [W*32-1:0] g;
        for (int l = 0; l < W; l++) g[l*32 +: 32] = rand_instr();
        return g;
    endfunction

    function automatic logic [W*32-1:0] pc_group(input logic [31:0] base);
        logic [W*32-1:0] g;
        for (int l = 0; l < W; l++) g[l*32 +: 32] = base + 32'(4 * l);
        return g;
    endfunction

    initial begin
        alu_tab = '{c_op_add, c_op_sll, c_op_slt, c_op_sltu, c_op_xor, c_op_srl, c_op_or, c_op_and};
        vecs[0]  = mkv(32'h00500093, FU_ALU,  1, 1, 0, 0, 0, 0, 32'h0000_0005);
        vecs[1]  = mkv(32'hFE000EE3, FU_BRU,  0, 1, 1, 0, 1, 0, 32'hFFFF_FFFC);
        vecs[2]  = mkv(32'h000000B7, FU_ALU,  1, 0, 0, 0, 0, 0, 32'h0000_0000);
        vecs[3]  = mkv(32'h0000006F, FU_BRU,  0, 0, 0, 0, 0, 1, 32'h0000_0000);
        vecs[4]  = mkv(32'hFFFFFFFF, FU_NONE, 0, 0, 0, 1, 0, 0, 32'h0000_0000);
        vecs[5]  = mkv(32'h02208033, FU_MUL,  0, 1, 1, 0, 0, 0, 32'h0000_0000);
        vecs[6]  = mkv(32'hFF812283, FU_LSU,  1, 1, 0, 0, 0, 0, 32'hFFFF_FFF8);
        vecs[7]  = mkv(32'h00322623, FU_LSU,  0, 1, 1, 0, 0, 0, 32'h0000_000C);
        vecs[8]  = mkv(32'h02C5C533, FU_DIV,  1, 1, 1, 0, 0, 0, 32'h0000_0000);
        vecs[9]  = mkv(32'h300110F3, FU_CSR,  1, 1, 0, 0, 0, 0, 32'h0000_0300);
        vecs[10] = mkv(32'h00000073, FU_CSR,  0, 0, 0, 0, 0, 0, 32'h0000_0000);
        vecs[11] = mkv(32'h40001033, FU_NONE, 0, 0, 0, 1, 0, 0, 32'h0000_0000);
        vecs[12] = mkv(32'h4030D093, FU_ALU,  1, 1, 0, 0, 0, 0, 32'h0000_0403);
        vecs[13] = mkv(32'h000280E7, FU_BRU,  1, 1, 0, 0, 0, 1, 32'h0000_0000);
        vecs[14] = mkv(32'h00000001, FU_NONE, 0, 0, 0, 1, 0, 0, 32'h0000_0000);
        vecs[15] = mkv(32'h0FF0000F, FU_ALU,  0, 0, 0, 0, 0, 0, 32'h0000_0000);

        // ---- reset with a valid group offered ----
        rst = 1'b1; flush = 1'b0; ibuf_valid = 1'b1; dec_ready = 1'b1;
        instrs = rand_group(); pcs = pc_group(32'h1000);
        for (int c = 0; c < 2; c++) begin
            drive(1, 0, 1, instrs, pcs, 1);
            check1("rst_dec_valid", dec_valid, 1'b0);
            check1("rst_ibuf_ready", ibuf_ready, 1'b0);
            check("rst_uops", uops, '0);
        end
        drive(0, 0, 0, instrs, pcs, 1);
        check1("post_rst_ready", ibuf_ready, 1'b1);
        check1("post_rst_valid", dec_valid, 1'b0);
        check("post_rst_uops", uops, '0);

        // ---- directed decode table, four lanes per group ----
        for (int g = 0; g < 4; g++) begin
            for (int l = 0; l < W; l++) ri[l*32 +: 32] = vecs[g*W + l].instr;
            rp = pc_group(32'h8000_0000 + 32'(16 * g));
            drive(0, 0, 1, ri, rp, 1);
            drive(0, 0, 0, ri, rp, 1);
            check1("tbl_valid", dec_valid, 1'b1);
            for (int l = 0; l < W; l++) begin
                u = uop_t'(uops[l*UW +: UW]);
                check($sformatf("tbl_vec%0d", g*W + l),
                      {u.fu, u.rd_we, u.rs1_en, u.rs2_en, u.illegal, u.is_branch, u.is_jump,
                       u.imm, u.pc, u.rd},
                      {vecs[g*W+l].fu, vecs[g*W+l].rd_we, vecs[g*W+l].rs1_en, vecs[g*W+l].rs2_en,
                       vecs[g*W+l].illegal, vecs[g*W+l].is_branch, vecs[g*W+l].is_jump,
                       vecs[g*W+l].imm, rp[l*32 +: 32], vecs[g*W+l].instr[11:7]});
            end
        end

        // ---- backpressure: A accepted, 4 stall cycles, then B and C in order ----
        ga = rand_group(); pa = pc_group(32'h2000);
        gb = rand_group(); pb = pc_group(32'h2010);
        gc = rand_group(); pc_c = pc_group(32'h2020);
        drive(0, 0, 1, ga, pa, 1);
        check1("bp_ready_a", ibuf_ready, 1'b1);
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 1, gb, pb, 0);
            check1("bp_stall_valid", dec_valid, 1'b1);
            check1("bp_stall_ready", ibuf_ready, 1'b0);
            check("bp_stall_uops", uops, ref_group(ga, pa));
        end
        drive(0, 0, 1, gb, pb, 1);
        check1("bp_release_ready", ibuf_ready, 1'b1);
        check("bp_release_uops", uops, ref_group(ga, pa));
        drive(0, 0, 1, gc, pc_c, 1);
        check1("bp_b_valid", dec_valid, 1'b1);
        check("bp_b_uops", uops, ref_group(gb, pb));
        drive(0, 0, 0, gc, pc_c, 1);
        check1("bp_c_valid", dec_valid, 1'b1);
        check("bp_c_uops", uops, ref_group(gc, pc_c));
        drive(0, 0, 0, gc, pc_c, 1);
        check1("bp_empty", dec_valid, 1'b0);

        // ---- flush while stalled with a group offered ----
        drive(0, 0, 1, ga, pa, 1);
        drive(0, 0, 1, gb, pb, 0);
        check("fl_held_uops", uops, ref_group(ga, pa));
        drive(0, 1, 1, gb, pb, 0);
        check1("fl_ready", ibuf_ready, 1'b0);
        drive(0, 0, 0, gb, pb, 0);
        check1("fl_valid_after", dec_valid, 1'b0);
        check1("fl_ready_after", ibuf_ready, 1'b1);

        // ---- flush together with dec_ready: input still refused ----
        drive(0, 1, 1, gc, pc_c, 1);
        check1("fl_rdy_ready", ibuf_ready, 1'b0);
        drive(0, 0, 0, gc, pc_c, 1);
        check1("fl_rdy_valid_after", dec_valid, 1'b0);

        // ---- random traffic against the reference model ----
        mvalid = 1'b0;
        mgrp   = '0;
        for (int c = 0; c < 1500; c++) begin
            rv  = ($urandom_range(0, 9) < 7);
            rdr = ($urandom_range(0, 9) < 6);
            rfl = ($urandom_range(0, 19) == 0);
            ri  = rand_group();
            rp  = pc_group({$urandom_range(0, 32'hFFFF), 16'h0});
            drive(0, rfl, rv, ri, rp, rdr);
            exp_rdy = !rfl && (!mvalid || rdr);
            check1("rnd_ready", ibuf_ready, exp_rdy);
            check1("rnd_valid", dec_valid, mvalid);
            if (mvalid) check("rnd_uops", uops, mgrp);
            if (rfl) mvalid = 1'b0;
            else if (rv && exp_rdy) begin
                mvalid = 1'b1;
                mgrp   = ref_group(ri, rp);
            end else if (mvalid && rdr) mvalid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_decode_stage
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode stage that consumes instruction groups popped from the ibuffer.
- Decodes DECODE_WIDTH RV32IM instructions per group into micro-ops.
- Holds the group in a one-deep pipeline register and hands it to rename/dispatch with a valid/ready handshake.
- Sits between the ibuffer and rename inside the backend; flush empties it.

Parameters:
- Cfg, config_pkg::EmptyCfg, global configuration; uses Cfg.ILEN (32) and Cfg.PLEN (32).
- DECODE_WIDTH, Cfg.INSTR_PER_FETCH, lanes per group (default 4 for tests).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  backend flush; kill held group and drop input this cycle.
- ibuf_valid_i  in  1  group valid from ibuffer.
- ibuf_ready_o  out  1  stage accepts group this cycle.
- ibuf_instrs_i  in  DECODE_WIDTH*ILEN  raw instructions, lane 0 oldest.
- ibuf_pcs_i  in  DECODE_WIDTH*PLEN  per-lane PC.
- dec_valid_o  out  1  decoded group valid.
- dec_ready_i  in  1  rename accepts group.
- dec_uops_o  out  DECODE_WIDTH*$bits(uop_t)  decoded micro-ops.

Behaviour:
- Reset: while rst_i is high at a clock edge, valid_q <= 0 and all uop registers <= 0 (fu = FU_NONE). Outputs after reset: dec_valid_o=0, dec_uops_o=0, ibuf_ready_o=1. Reset has priority over flush and handshakes. If reset is asserted mid-stall, the held group is discarded.
- Handshake: ibuf_ready_o = !flush_i && (!valid_q || dec_ready_i). fire_in = ibuf_valid_i && ibuf_ready_o. fire_out = valid_q && dec_ready_i.
- Latency: 1 cycle. A group accepted at edge N appears on dec_uops_o with dec_valid_o=1 after edge N.
- Throughput: one group per cycle when dec_ready_i stays high (pass-through).
- Stall: when valid_q && !dec_ready_i, outputs hold bit-stable and ibuf_ready_o=0.
- Register update, in priority order:
  - flush_i: valid_q <= 0; input is not taken.
  - fire_in: valid_q <= 1; uops <= decode(inputs).
  - fire_out only: valid_q <= 0.
  - otherwise: hold.
- Flush and dec_ready_i in the same cycle: flush wins; rename must ignore dec_valid_o in a flush cycle.
- Per-lane decode (combinational, before the register):
  - opcode classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP(M ext funct7=0000001), MISC-MEM (FENCE treated as ALU nop), SYSTEM (ECALL/EBREAK/CSR*).
  - fu: FU_ALU, FU_BRU, FU_LSU, FU_MUL, FU_DIV, FU_CSR, FU_NONE.
  - op: 5-bit sub-op from funct3/funct7.
  - rs1/rs2/rd: 5 bits each. rs1_en/rs2_en per format. rd_we = format writes && rd != 0.
  - imm: 32 bits, sign-extended per I/S/B/U/J format. B and J immediates keep bit0 = 0. U immediate = instr[31:12]<<12.
  - illegal = 1 for unknown opcode, bad funct3/funct7 combination, or instr[1:0] != 2'b11. Illegal lanes have fu=FU_NONE, rd_we=0, and still pass through so the exception is raised in order.
  - pc and instr are copied into the uop.
- Every lane in a group is valid; a per-lane mask is not supported.

Decomposition:
- decode_pkg holds:
  - fu_e enum (3 bits).
  - op encodings (localparams).
  - RV32 opcode localparams.
  - uop_t struct: pc, instr, fu, op, rs1, rs2, rd, rs1_en, rs2_en, rd_we, imm, illegal, is_branch, is_jump.
- One sub-module, rv_decoder: purely combinational, one instruction in and one uop_t out, instantiated DECODE_WIDTH times in a generate loop.
- decode_stage keeps only the handshake and pipeline register.

Test Plan:
- Reset: hold rst_i 2 cycles, ibuf_valid_i=1 -> dec_valid_o=0, ibuf_ready_o=0 during reset, ibuf_ready_o=1 after.
- Basic decode: lane0 = 0x00500093 (addi x1,x0,5) at pc 0x80000000, dec_ready_i=1 -> next cycle fu=ALU, rd=1, rd_we=1, rs1_en=1, rs2_en=0, imm=5, pc=0x80000000.
- Immediate sign-extension: lane1 = 0xFE000EE3 (beq x0,x0,-4) -> fu=BRU, imm=0xFFFFFFFC, rd_we=0, is_branch=1. lane2 = 0x000000B7 (lui x1,0) -> imm=0. lane3 = 0x0000006F (jal x0,0) -> rd_we=0.
- Backpressure: 3 back-to-back groups with dec_ready_i low for 4 cycles after the first -> first group held stable, ibuf_ready_o=0; groups 2 and 3 emerge in order, none lost or duplicated.
- Flush: flush_i=1 while stalled and ibuf_valid_i=1 -> next cycle dec_valid_o=0, and the input group was not consumed (ibuf_ready_o=0 in the flush cycle).
- Illegal and M-extension: 0xFFFFFFFF -> illegal=1, fu=FU_NONE, rd_we=0. 0x02208033 (mul x0,x1,x2) -> fu=MUL, rd_we=0.
